// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and 8N1 frame constants.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned IDX_W      = 3;
    localparam logic        STOP_LEVEL = 1'b1;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count (tick) and
// the cycle before it (tick_pre), both from flops so consumers can register off them.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_pre
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          pre_q, pre_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick_q) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == LAST);
        pre_d  = (cnt_d == PRE);
    end

    // Flags track the counter value they describe, so reset matches count 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            pre_q  <= (PRE == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            pre_q  <= pre_d;
        end
    end

    assign tick     = tick_q;
    assign tick_pre = pre_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. All outputs are flops loaded from next-state values,
// so tx/busy change in the cycle after the decision that causes them.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 tick_pre;
    logic                 timer_clear;

    // Timer held at zero while idle so START always begins at count 0.
    assign timer_clear = (state_q == IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .tick    (tick),
        .tick_pre(tick_pre)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    shift_d = tx_data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Raise done one cycle early so the flop is high on the terminal cycle.
                done_d = tick_pre;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:    tx_d = IDLE_LEVEL;
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = STOP_LEVEL;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10416 (100 MHz / 9600 baud), meaning clock cycles per serial bit, legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tx_data, input, 8 bits: the byte to send, sampled only on an accepted start.
REQ-005 The block SHALL have port tx_start, input, 1 bit: the send request, level-sampled.
REQ-006 The block SHALL have port tx, output, 1 bit: the serial line, idle high, registered.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a frame is in progress, registered.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse at frame end, registered.

Function
REQ-009 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-010 The state machine SHALL have states IDLE, START, DATA and STOP.
REQ-011 In IDLE, tx_start=1 SHALL be accepted at that edge: latch tx_data into a shift register, clear the bit-timer and bit index, and go to START.
REQ-012 tx SHALL be 0 and busy SHALL be 1 from the cycle after acceptance, giving one cycle of latency from tx_start to the start-bit edge.
REQ-013 The bit-timer SHALL count 0..CLKS_PER_BIT-1; at terminal count it SHALL reset to 0 and the FSM SHALL advance as follows.
REQ-014 START SHALL go to DATA; DATA SHALL go to DATA after bits 0..6 and to STOP after bit 7.
REQ-015 The data bit index SHALL be 3 bits, and it SHALL NOT wrap in use because the FSM leaves DATA on index 7.
REQ-016 In DATA, tx SHALL equal the LSB of the shift register, and the register SHALL shift right by one at each bit boundary.
REQ-017 STOP SHALL drive tx=1; at terminal count it SHALL assert done for exactly that one cycle and go to IDLE.
REQ-018 The total frame SHALL last exactly 10*CLKS_PER_BIT cycles with busy=1.
REQ-019 tx_start while busy=1, including the done cycle, SHALL be ignored, and tx_data changes during a frame SHALL NOT affect it.
REQ-020 With tx_start held high continuously, frames SHALL repeat with exactly one IDLE cycle (tx=1, busy=0) between the done cycle and the next start bit.
REQ-021 In IDLE, tx SHALL be 1, busy SHALL be 0 and done SHALL be 0.

Reset
REQ-022 reset=0 SHALL immediately force state=IDLE, tx=1, busy=0, done=0, bit-timer=0, bit index=0 and shift register=0, regardless of the clock.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse; tx SHALL return high asynchronously.
REQ-024 After reset release, the first tx_start SHALL be honoured at the first rising edge with reset=1.

Structure
REQ-025 State encodings (IDLE=0, START=1, DATA=2, STOP=3) and the frame constants DATA_BITS=8 and STOP_LEVEL=1 SHALL live in a shared package, uart_pkg.
REQ-026 The bit-timer SHALL be one sub-module, baud_tick, with parameter CLKS_PER_BIT, ports clk, reset, clear and tick, a counter of width clog2(CLKS_PER_BIT), and tick high on the terminal-count cycle.
REQ-027 All outputs SHALL come directly from flops, with no combinational path from inputs to outputs.

Verification (CLKS_PER_BIT=4)
REQ-028 Send 0xA5: tx_start pulse with tx_data=0xA5 -> tx SHALL show, in 4-cycle bits, 0,1,0,1,0,0,1,0,1,1; done SHALL pulse in cycle 40 after acceptance; busy SHALL be high for 40 cycles.
REQ-029 Ignore while busy: accept 0x3C, then tx_start pulse with tx_data=0xFF at cycle 10 -> the line SHALL carry only 0x3C, and tx SHALL stay 1 after done.
REQ-030 Back-to-back: tx_start held high, with 0x00 then 0xFF -> there SHALL be exactly one idle cycle (tx=1, busy=0) between the done pulse and the second start bit.
REQ-031 Reset mid-frame: reset=0 at cycle 15 of a 0x00 frame -> tx=1 and busy=0 SHALL hold within the same cycle, with no done pulse; after release, a frame with 0x81 SHALL be sent correctly.
REQ-032 Power-on: reset=0 held for 5 cycles with tx_start=1 -> tx=1, busy=0 and done=0 SHALL hold throughout, and the start bit SHALL begin one cycle after the first edge with reset=1.
